// File: rtl/axi_rr_arb_slice_if.sv
// axi_rr_arb_slice_if
//   Request-side and downstream-side signals of the round-robin arbiter slice.
//   slave  : arbiter view (consumes requests/pointer/ready, drives grant/slice outputs)
//   master : environment view (drives requests/pointer/ready)
//   Signals: rr_flag_i, req_i, data_i, ready_i  -> arbiter
//            gnt_o, valid_o, data_o, id_o, flag_update_o <- arbiter
interface axi_rr_arb_slice_if #(
  parameter int N_REQ      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = $clog2(N_REQ)
);
  logic [FLAG_WIDTH-1:0]       rr_flag_i;
  logic [N_REQ-1:0]            req_i;
  logic [N_REQ*DATA_WIDTH-1:0] data_i;
  logic [N_REQ-1:0]            gnt_o;
  logic                        valid_o;
  logic [DATA_WIDTH-1:0]       data_o;
  logic [FLAG_WIDTH-1:0]       id_o;
  logic                        ready_i;
  logic                        flag_update_o;

  modport slave (
    input  rr_flag_i, req_i, data_i, ready_i,
    output gnt_o, valid_o, data_o, id_o, flag_update_o
  );

  modport master (
    output rr_flag_i, req_i, data_i, ready_i,
    input  gnt_o, valid_o, data_o, id_o, flag_update_o
  );
endinterface

// File: rtl/axi_rr_arb_slice.sv
// axi_rr_arb_slice
//   Round-robin arbiter over N_REQ requesters feeding a one-entry registered
//   output slice. The search starts at the externally supplied pointer
//   rr_flag_i; the accept pulse flag_update_o advances that pointer outside.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : axi_rr_arb_slice_if.slave (requests, pointer, grant, slice, ready)
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | slice holds nothing, valid_o=0
// ST_FULL  | slice holds winner payload/index, valid_o=1
module axi_rr_arb_slice #(
  parameter int N_REQ      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axi_rr_arb_slice_if.slave       bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // One extra bit so start+offset never overflows before the modulo fold.
  localparam logic [FLAG_WIDTH:0] LP_N = (FLAG_WIDTH+1)'(N_REQ);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [FLAG_WIDTH-1:0]   r_id;

  logic [FLAG_WIDTH:0]     w_start;
  logic                    w_found;
  logic [FLAG_WIDTH-1:0]   w_win;
  logic [DATA_WIDTH-1:0]   w_win_data;
  logic                    w_grant_en;
  logic [N_REQ-1:0]        w_gnt;
  logic                    w_accept;

  // Rotating priority search: first requester at or after the pointer wins.
  always_comb begin : sel
    logic [FLAG_WIDTH:0] v_idx;
    v_idx      = '0;
    w_start    = {1'b0, bus.rr_flag_i};
    if (w_start >= LP_N) w_start = '0;
    w_found    = 1'b0;
    w_win      = '0;
    w_win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v_idx = w_start + (FLAG_WIDTH+1)'(i);
      if (v_idx >= LP_N) v_idx = v_idx - LP_N;
      if (!w_found && bus.req_i[v_idx[FLAG_WIDTH-1:0]]) begin
        w_found    = 1'b1;
        w_win      = v_idx[FLAG_WIDTH-1:0];
        w_win_data = bus.data_i[int'(v_idx[FLAG_WIDTH-1:0])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // rst_n gates the grant so nothing is handed out while held in reset.
  assign w_grant_en = rst_n & ((r_state == ST_EMPTY) | bus.ready_i);

  always_comb begin
    w_gnt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_gnt[k] = w_grant_en & w_found & (w_win == FLAG_WIDTH'(k));
    end
  end

  assign w_accept = |w_gnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_accept)         w_state_nxt = ST_FULL;
        else if (bus.ready_i) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Slice payload; holds its last value when draining without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_id   <= '0;
    end else if (w_accept) begin
      r_data <= w_win_data;
      r_id   <= w_win;
    end
  end

  // Outputs
  always_comb begin
    bus.valid_o       = (r_state == ST_FULL);
    bus.data_o        = r_data;
    bus.id_o          = r_id;
    bus.gnt_o         = w_gnt;
    bus.flag_update_o = w_accept;
  end

endmodule

// File: tb/tb_axi_rr_arb_slice.sv
module tb_axi_rr_arb_slice;
  localparam int N  = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  axi_rr_arb_slice_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  axi_rr_arb_slice #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference state
  logic [DW-1:0] d [N];
  int            cur_flag;
  logic [N-1:0]  cur_req;
  logic          cur_rdy;
  logic          m_valid;
  int            m_id;
  logic [DW-1:0] m_data;
  int            q_id[$];
  logic [DW-1:0] q_data[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Winner by the rotation rule: scan from the pointer (0 if out of range), wrap mod N.
  function automatic int pick(input int flag, input logic [N-1:0] req);
    int s;
    s = (flag >= N) ? 0 : flag;
    for (int j = 0; j < N; j++) begin
      if (req[(s + j) % N]) return (s + j) % N;
    end
    return -1;
  endfunction

  task automatic drive(input int flag, input logic [N-1:0] req, input logic rdy);
    cur_flag = flag;
    cur_req  = req;
    cur_rdy  = rdy;
    bus.rr_flag_i = flag[2:0];
    bus.req_i     = req;
    bus.ready_i   = rdy;
    for (int k = 0; k < N; k++) bus.data_i[k*DW +: DW] = d[k];
  endtask

  task automatic evaluate(output int win);
    int w;
    logic acc;
    logic [N-1:0] g;
    w   = pick(cur_flag, cur_req);
    acc = (w >= 0) && (!m_valid || cur_rdy);
    g   = '0;
    if (acc) g[w] = 1'b1;
    check("gnt",         64'(bus.gnt_o),         64'(g));
    check("flag_update", 64'(bus.flag_update_o), 64'(acc));
    check("valid",       64'(bus.valid_o),       64'(m_valid));
    check("id_hold",     64'(bus.id_o),          64'(m_id));
    check("data_hold",   64'(bus.data_o),        64'(m_data));
    if (acc) begin
      q_id.push_back(w);
      q_data.push_back(d[w]);
      m_valid = 1'b1;
      m_id    = w;
      m_data  = d[w];
      win     = w;
    end else begin
      if (m_valid && cur_rdy) m_valid = 1'b0;
      win = -1;
    end
  endtask

  task automatic cyc(input int flag, input logic [N-1:0] req, input logic rdy, output int win);
    @(negedge clk);
    drive(flag, req, rdy);
    #2;
    evaluate(win);
  endtask

  // Monitor: whenever the DUT signals an accept, the slice presents a new entry after the edge.
  initial begin
    logic fu;
    int   eid;
    logic [DW-1:0] edata;
    forever begin
      @(negedge clk);
      #6;
      fu = bus.flag_update_o;
      @(posedge clk);
      #1;
      if (fu) begin
        if (q_id.size() == 0) begin
          check("unexpected_entry", 64'(bus.valid_o), 64'(0));
        end else begin
          eid   = q_id.pop_front();
          edata = q_data.pop_front();
          check("sb_valid", 64'(bus.valid_o), 64'(1));
          check("sb_id",    64'(bus.id_o),    64'(eid));
          check("sb_data",  64'(bus.data_o),  64'(edata));
        end
      end
    end
  end

  initial begin
    int w;
    int flag;
    logic [N-1:0] pend;
    logic [N-1:0] all_req;
    all_req = '1;
    for (int k = 0; k < N; k++) d[k] = $urandom;
    m_valid = 1'b0; m_id = 0; m_data = '0;
    rst_n = 1'b0;
    drive(0, all_req, 1'b1);
    #5;
    check("rst_gnt",   64'(bus.gnt_o),         64'(0));
    check("rst_fu",    64'(bus.flag_update_o), 64'(0));
    check("rst_valid", 64'(bus.valid_o),       64'(0));
    check("rst_id",    64'(bus.id_o),          64'(0));
    check("rst_data",  64'(bus.data_o),        64'(0));
    @(negedge clk);
    drive(0, '0, 1'b1);
    #1 rst_n = 1'b1;

    // basic grant
    d[1] = 32'hA5A5_0001;
    cyc(0, 8'b0000_0110, 1'b1, w);
    check("basic_win", 64'(w), 64'(1));
    cyc(0, 8'b0000_0000, 1'b1, w);
    // rotation
    cyc(5, 8'b0100_0100, 1'b1, w);
    check("rot_win", 64'(w), 64'(6));
    cyc(0, 8'b0000_0000, 1'b1, w);
    // wrap-around
    cyc(7, 8'b0000_1001, 1'b1, w);
    check("wrap_win", 64'(w), 64'(0));
    cyc(0, 8'b0000_0000, 1'b1, w);
    cyc(0, 8'b0000_0000, 1'b1, w);

    // backpressure
    cyc(3, 8'b0000_1000, 1'b1, w);
    repeat (5) cyc(0, all_req, 1'b0, w);
    cyc(2, all_req, 1'b1, w);
    check("bp_release_win", 64'(w), 64'(2));
    cyc(0, '0, 1'b1, w);
    cyc(0, '0, 1'b1, w);

    // streaming with an RR flag counter that advances on each accept
    flag = 0;
    for (int i = 0; i < 17; i++) begin
      d[i % N] = $urandom;
      cyc(flag, all_req, 1'b1, w);
      check("stream_id", 64'(w), 64'(i % N));
      if (w >= 0) flag = (flag + 1) % N;
    end
    cyc(0, '0, 1'b1, w);
    cyc(0, '0, 1'b1, w);

    // reset mid-operation while FULL with id 4 and backpressured
    cyc(4, 8'b0001_0000, 1'b1, w);
    cyc(0, '0, 1'b0, w);
    @(negedge clk);
    drive(0, all_req, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.valid_o),       64'(0));
    check("mid_rst_id",    64'(bus.id_o),          64'(0));
    check("mid_rst_data",  64'(bus.data_o),        64'(0));
    check("mid_rst_gnt",   64'(bus.gnt_o),         64'(0));
    check("mid_rst_fu",    64'(bus.flag_update_o), 64'(0));
    m_valid = 1'b0; m_id = 0; m_data = '0;
    #1 rst_n = 1'b1;
    #1;
    evaluate(w);
    cyc(0, '0, 1'b1, w);
    cyc(0, '0, 1'b1, w);

    // randomized: requests stay asserted with stable data until granted
    pend = '0;
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom_range(0, 2) == 0)) begin
          pend[k] = 1'b1;
          d[k]    = $urandom;
        end
      end
      cyc(int'($urandom_range(0, N-1)), pend, 1'($urandom_range(0, 3) != 0), w);
      if (w >= 0) pend[w] = 1'b0;
    end

    repeat (3) cyc(0, '0, 1'b1, w);
    @(negedge clk);
    check("sb_leftover", 64'(q_id.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_rr_arb_slice.md
# axi_rr_arb_slice

Round-robin request arbiter with a one-entry registered output, for AXI node request channels. It consumes the round-robin pointer produced by the node's RR flag counter and selects one of N_REQ requesters, starting the search at that pointer. It registers the winner's payload and index toward the downstream channel. It returns an accept pulse that the flag counter uses as its req&gnt advance condition.

## Interface
- N_REQ, 8: number of requesters (≥2).
- DATA_WIDTH, 32: payload bits per requester.
- FLAG_WIDTH, $clog2(N_REQ): width of the RR pointer and of id_o.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- rr_flag_i  in  FLAG_WIDTH  round-robin start index, from the RR flag counter.
- req_i  in  N_REQ  per-requester valid; must stay high with stable data until granted.
- data_i  in  N_REQ*DATA_WIDTH  payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- gnt_o  out  N_REQ  one-hot (or zero) combinational grant.
- valid_o  out  1  output slice holds a valid entry.
- data_o  out  DATA_WIDTH  registered payload of the winner.
- id_o  out  FLAG_WIDTH  registered index of the winner.
- ready_i  in  1  downstream ready.
- flag_update_o  out  1  combinational; high in any cycle an input is accepted. Drives the flag counter's req and gnt inputs.

## Operation
- Slice has two states: EMPTY (valid_o=0) and FULL (valid_o=1).
- can_accept = !valid_o | ready_i. This gives pass-through drain and fill in the same cycle.
- Selection:
  - Scan indices rr_flag_i, rr_flag_i+1, … modulo N_REQ.
  - The first k with req_i[k]=1 wins.
  - If rr_flag_i ≥ N_REQ (non-power-of-2 N_REQ), the scan starts at 0.
- gnt_o[k] = winner==k & can_accept. gnt_o=0 when no request or !can_accept.
- flag_update_o = |gnt_o.
- On a clock edge with flag_update_o=1: data_o←winner payload, id_o←k, valid_o←1.
- On a clock edge with valid_o & ready_i & !flag_update_o: valid_o←0. data_o and id_o hold their last value.
- While FULL and !ready_i: data_o, id_o and valid_o are held; gnt_o=0.
- Winner index arithmetic is modulo N_REQ, with no out-of-range id_o. The wrap index computation must be at least FLAG_WIDTH+1 bits wide.
- The block has no state other than the slice. Priority comes entirely from rr_flag_i, so a grant with rr_flag_i unchanged re-selects by the same priority.

## Timing
- Reset values: valid_o=0, data_o=0, id_o=0. Combinational outputs follow from these: gnt_o=0 until requests are seen; flag_update_o=0.
- Latency: request accepted in cycle t → valid_o/data_o/id_o visible in cycle t+1.
- Throughput: one transfer per cycle with ready_i held high.
- rr_flag_i is sampled combinationally each cycle. The flag counter updates it one cycle after flag_update_o, so back-to-back arbitration uses the advanced pointer.
- Simultaneous drain and accept (FULL, ready_i=1, request present): new entry loaded and valid_o stays 1.
- rst_n asserted mid-transfer: the entry is dropped immediately (async), and all outputs go to reset values. No grant may be issued while rst_n=0.
- No combinational path from ready_i to valid_o. There are paths from req_i/rr_flag_i/ready_i to gnt_o and flag_update_o.

## Test plan
- Basic grant: reset, rr_flag_i=0, req_i=8'b0000_0110, data1=0xA5A5_0001, ready_i=1.
  - gnt_o=8'b0000_0010 and flag_update_o=1.
  - Next cycle: valid_o=1, id_o=1, data_o=0xA5A5_0001.
- Rotation: rr_flag_i=5, req_i bits 2 and 6 set → gnt_o=8'b0100_0000, and id_o=6 next cycle.
- Wrap-around: rr_flag_i=7, req_i bits 0 and 3 set → gnt_o=8'b0000_0001, and id_o=0 next cycle.
- Backpressure: FULL with ready_i=0 for 5 cycles and req_i=8'hFF.
  - gnt_o=0, flag_update_o=0, and data_o/id_o stable throughout.
  - When ready_i→1, a new grant is issued the same cycle.
- Streaming with a real RR flag counter connected, all 8 requesters always requesting, ready_i=1:
  - id_o sequence 0,1,2,…,7,0; one transfer per cycle.
  - flag_update_o high every cycle.
- Reset mid-operation: FULL with id_o=4 and ready_i=0, pulse rst_n low between clock edges.
  - valid_o=0, data_o=0 and id_o=0 immediately.
  - Normal operation resumes after release.
